// File: rtl/a2d_sched.sv
// a2d_sched: round-robin conversion scheduler for the shared A2D converter.
// Each request runs two SPI transactions on the next channel in rotation:
// lft, rght, then batt. The first transaction selects the channel and the
// second one returns its data, which is latched into that channel's holding
// register. A single request arriving mid-conversion is remembered.
// Optional feature macro: A2D_BATT_CHK_EN adds the registered batt_low flag.
module a2d_sched #(
    parameter logic [2:0]  LFT_CHNL    = 3'd0,
    parameter logic [2:0]  RGHT_CHNL   = 3'd4,
    parameter logic [2:0]  BATT_CHNL   = 3'd5,
    parameter logic [11:0] BATT_THRESH = 12'h800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        all_vld
`ifdef A2D_BATT_CHK_EN
   ,output logic        batt_low
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND1 = 3'd1,
        WAIT1 = 3'd2,
        GAP   = 3'd3,
        SEND2 = 3'd4,
        WAIT2 = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic        pend_q, pend_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] batt_q, batt_d;
    logic        cmplt_q, cmplt_d;
    logic        lft_seen_q, lft_seen_d;
    logic        rght_seen_q, rght_seen_d;
    logic        all_vld_q, all_vld_d;
`ifdef A2D_BATT_CHK_EN
    logic        batt_low_q, batt_low_d;
`endif

    // Map rotation slot to the A2D channel number; slot 3 is never used.
    function automatic logic [2:0] chnl_of(input logic [1:0] slot);
        case (slot)
            2'd0:    chnl_of = LFT_CHNL;
            2'd1:    chnl_of = RGHT_CHNL;
            default: chnl_of = BATT_CHNL;
        endcase
    endfunction

    // SPI command word: channel select in bits [13:11], everything else zero.
    function automatic logic [15:0] cmd_of(input logic [1:0] slot);
        cmd_of = {2'b00, chnl_of(slot), 11'h000};
    endfunction

    // Next-state and registered-output logic for the conversion sequencer.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        pend_d      = pend_q;
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        lft_d       = lft_q;
        rght_d      = rght_q;
        batt_d      = batt_q;
        cmplt_d     = 1'b0;
        lft_seen_d  = lft_seen_q;
        rght_seen_d = rght_seen_q;
        all_vld_d   = all_vld_q;
`ifdef A2D_BATT_CHK_EN
        batt_low_d  = batt_low_q;
`endif
        case (state_q)
            IDLE: begin
                if (nxt || pend_q) begin
                    state_d = SEND1;
                    pend_d  = 1'b0;
                    wrt_d   = 1'b1;
                    cmd_d   = cmd_of(rr_q);
                end
            end
            SEND1: state_d = WAIT1;
            WAIT1: begin
                if (done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = SEND2;
                wrt_d   = 1'b1;
            end
            SEND2: state_d = WAIT2;
            WAIT2: begin
                if (done) begin
                    state_d = IDLE;
                    cmplt_d = 1'b1;
                    rr_d    = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
                    case (rr_q)
                        2'd0: begin
                            lft_d      = rd_data[11:0];
                            lft_seen_d = 1'b1;
                        end
                        2'd1: begin
                            rght_d      = rd_data[11:0];
                            rght_seen_d = 1'b1;
                        end
                        default: begin
                            batt_d = rd_data[11:0];
                            if (lft_seen_q && rght_seen_q) begin
                                all_vld_d = 1'b1;
                            end
`ifdef A2D_BATT_CHK_EN
                            batt_low_d = (rd_data[11:0] < BATT_THRESH);
`endif
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
        // A request outside IDLE (including the completion cycle) is held
        // as a single pending request; extra ones are dropped.
        if (nxt && (state_q != IDLE)) begin
            pend_d = 1'b1;
        end
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 2'd0;
            pend_q      <= 1'b0;
            wrt_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            lft_q       <= 12'h000;
            rght_q      <= 12'h000;
            batt_q      <= 12'h000;
            cmplt_q     <= 1'b0;
            lft_seen_q  <= 1'b0;
            rght_seen_q <= 1'b0;
            all_vld_q   <= 1'b0;
`ifdef A2D_BATT_CHK_EN
            batt_low_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            pend_q      <= pend_d;
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            lft_q       <= lft_d;
            rght_q      <= rght_d;
            batt_q      <= batt_d;
            cmplt_q     <= cmplt_d;
            lft_seen_q  <= lft_seen_d;
            rght_seen_q <= rght_seen_d;
            all_vld_q   <= all_vld_d;
`ifdef A2D_BATT_CHK_EN
            batt_low_q  <= batt_low_d;
`endif
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;
    assign cnv_cmplt = cmplt_q;
    assign all_vld   = all_vld_q;

    // The A2D status nibble carries no sample data and is deliberately dropped.
    logic unused_bits;
`ifdef A2D_BATT_CHK_EN
    assign batt_low    = batt_low_q;
    assign unused_bits = ^rd_data[15:12];
`else
    assign unused_bits = ^{rd_data[15:12], BATT_THRESH};
`endif

endmodule

// File: tb/tb_a2d_sched.sv
// Directed testbench for a2d_sched with a small SPI/A2D behavioural model.
// The A2D model returns the sample of the channel selected by the previous
// transaction, with a non-zero upper nibble that the scheduler must drop.
module tb_a2d_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        wrt;
    logic [15:0] cmd;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        cnv_cmplt;
    logic        all_vld;
`ifdef A2D_BATT_CHK_EN
    logic        batt_low;
`endif

    a2d_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .rd_data   (rd_data),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .all_vld   (all_vld)
`ifdef A2D_BATT_CHK_EN
       ,.batt_low  (batt_low)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // A2D sample values per channel
    logic [11:0] lft_val  = 12'h130;
    logic [11:0] rght_val = 12'h190;
    logic [11:0] batt_val = 12'h9A0;
    bit          spi_hold = 1'b0;
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [2:0]  cur_ch = 3'd7;
    logic [2:0]  prev_ch = 3'd7;

    function automatic logic [11:0] adc_val(input logic [2:0] ch);
        case (ch)
            3'd0:    adc_val = lft_val;
            3'd4:    adc_val = rght_val;
            3'd5:    adc_val = batt_val;
            default: adc_val = 12'hEEE;
        endcase
    endfunction

    // SPI master + A2D model: done three cycles after wrt unless held off
    initial forever begin
        @(negedge clk);
        done = 1'b0;
        if (!rst_n) begin
            busy    = 1'b0;
            prev_ch = 3'd7;
        end else begin
            if (busy) begin
                if (cnt > 1) cnt--;
                else if (!spi_hold) begin
                    done    = 1'b1;
                    rd_data = {4'hA, adc_val(prev_ch)};
                    prev_ch = cur_ch;
                    busy    = 1'b0;
                end
            end
            if (wrt) begin
                busy   = 1'b1;
                cnt    = 3;
                cur_ch = cmd[13:11];
            end
        end
    end

    // Strobe counters sampled just after each rising edge
    int wrt_cnt = 0;
    int cmplt_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (wrt) wrt_cnt++;
        if (cnv_cmplt) cmplt_cnt++;
    end

    task automatic pulse_nxt();
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic start_conv(input string tag, input logic [15:0] exp_cmd);
        pulse_nxt();
        check_val({tag, "_wrt"}, {15'd0, wrt}, 16'd1);
        check_val({tag, "_cmd"}, cmd, exp_cmd);
    endtask

    task automatic wait_cmplt(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cnv_cmplt !== 1'b1 && n < 200);
        check_val({tag, "_cmplt"}, {15'd0, cnv_cmplt}, 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_val("rst_wrt", {15'd0, wrt}, 16'd0);
        check_val("rst_cmd", cmd, 16'h0000);
        check_val("rst_lft", {4'd0, lft_ld}, 16'h0000);
        check_val("rst_rght", {4'd0, rght_ld}, 16'h0000);
        check_val("rst_batt", {4'd0, batt}, 16'h0000);
        check_val("rst_cmplt", {15'd0, cnv_cmplt}, 16'd0);
        check_val("rst_allvld", {15'd0, all_vld}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic rotation: lft, rght, batt, then lft again
        start_conv("c1", 16'h0000);
        wait_cmplt("c1");
        check_val("c1_lft", {4'd0, lft_ld}, 16'h0130);
        check_val("c1_allvld", {15'd0, all_vld}, 16'd0);
        start_conv("c2", 16'h2000);
        wait_cmplt("c2");
        check_val("c2_rght", {4'd0, rght_ld}, 16'h0190);
        check_val("c2_allvld", {15'd0, all_vld}, 16'd0);
        start_conv("c3", 16'h2800);
        wait_cmplt("c3");
        check_val("c3_batt", {4'd0, batt}, 16'h09A0);
        check_val("c3_allvld", {15'd0, all_vld}, 16'd1);
        start_conv("c4", 16'h0000);
        wait_cmplt("c4");
        check_val("c4_lft", {4'd0, lft_ld}, 16'h0130);

        // Three requests during one conversion collapse into one pending
        rght_val = 12'h1A5;
        batt_val = 12'h9B0;
        @(negedge clk);
        wrt_cnt   = 0;
        cmplt_cnt = 0;
        start_conv("p1", 16'h2000);
        repeat (3) begin
            @(negedge clk);
            nxt = 1'b1;
            @(negedge clk);
            nxt = 1'b0;
        end
        wait_cmplt("p1");
        check_val("p1_rght", {4'd0, rght_ld}, 16'h01A5);
        @(negedge clk);
        check_val("b2b_wrt", {15'd0, wrt}, 16'd1);
        check_val("b2b_cmd", cmd, 16'h2800);
        wait_cmplt("p2");
        check_val("p2_batt", {4'd0, batt}, 16'h09B0);
        repeat (40) @(negedge clk);
        check_val("pend_wrts", wrt_cnt[15:0], 16'd4);
        check_val("pend_cmplts", cmplt_cnt[15:0], 16'd2);

        // SPI done held off in WAIT1
        lft_val  = 12'h3C3;
        spi_hold = 1'b1;
        wrt_cnt   = 0;
        cmplt_cnt = 0;
        start_conv("h", 16'h0000);
        repeat (100) @(negedge clk);
        check_val("h_wrts", wrt_cnt[15:0], 16'd1);
        check_val("h_cmplts", cmplt_cnt[15:0], 16'd0);
        check_val("h_lft", {4'd0, lft_ld}, 16'h0130);
        spi_hold = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        check_val("h_done", {15'd0, done}, 16'd1);
        @(negedge clk);
        check_val("h_gap", {15'd0, wrt}, 16'd0);
        @(negedge clk);
        check_val("h_wrt2", {15'd0, wrt}, 16'd1);
        wait_cmplt("h");
        check_val("h_lft2", {4'd0, lft_ld}, 16'h03C3);

        // Reset asserted during WAIT2
        start_conv("r", 16'h2000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wrt !== 1'b1 && n < 20);
        check_val("r_wrt2", {15'd0, wrt}, 16'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("r_wrt", {15'd0, wrt}, 16'd0);
        check_val("r_cmd", cmd, 16'h0000);
        check_val("r_lft", {4'd0, lft_ld}, 16'h0000);
        check_val("r_rght", {4'd0, rght_ld}, 16'h0000);
        check_val("r_batt", {4'd0, batt}, 16'h0000);
        check_val("r_cmplt", {15'd0, cnv_cmplt}, 16'd0);
        check_val("r_allvld", {15'd0, all_vld}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_conv("post", 16'h0000);
        wait_cmplt("post");
        check_val("post_lft", {4'd0, lft_ld}, 16'h03C3);
        check_val("post_rght", {4'd0, rght_ld}, 16'h0000);

`ifdef A2D_BATT_CHK_EN
        // Battery threshold: 7FF is low, 800 is not
        batt_val = 12'h7FF;
        start_conv("bl1", 16'h2000);
        wait_cmplt("bl1");
        start_conv("bl2", 16'h2800);
        wait_cmplt("bl2");
        check_val("batt_low_7ff", {15'd0, batt_low}, 16'd1);
        start_conv("bl3", 16'h0000);
        wait_cmplt("bl3");
        start_conv("bl4", 16'h2000);
        wait_cmplt("bl4");
        batt_val = 12'h800;
        start_conv("bl5", 16'h2800);
        wait_cmplt("bl5");
        check_val("batt_low_800", {15'd0, batt_low}, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2d_sched.md
# a2d_sched

Round-robin conversion scheduler for the off-board A2D converter serving the left load cell, right load cell and battery. It sits between the Segway top-level consumers (steering enable, balance control, battery monitor) and the shared SPI master that talks to the A2D. Each request starts one two-transaction SPI conversion on the next channel in rotation and updates a holding register for that channel. It also queues a single request that arrives while a conversion is in flight.

## Interface
- `LFT_CHNL`, default 3'd0, A2D channel of left load cell
- `RGHT_CHNL`, default 3'd4, A2D channel of right load cell
- `BATT_CHNL`, default 3'd5, A2D channel of battery
- `BATT_THRESH`, default 12'h800, battery-low threshold (used only with `A2D_BATT_CHK_EN`)

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous active-low reset
- `nxt` in 1: one-cycle request to convert the next channel
- `wrt` out 1: one-cycle strobe to SPI master to start a 16-bit transaction
- `cmd` out 16: SPI command word, `{2'b00, chnl[2:0], 11'h000}`
- `done` in 1: one-cycle pulse from SPI master, transaction complete
- `rd_data` in 16: SPI receive word, valid on `done`
- `lft_ld` out 12: latest left load cell sample
- `rght_ld` out 12: latest right load cell sample
- `batt` out 12: latest battery sample
- `cnv_cmplt` out 1: one-cycle pulse when a holding register updates
- `all_vld` out 1: set once all three channels have been sampled since reset
- `batt_low` out 1: battery below threshold (present only with `A2D_BATT_CHK_EN`)

## Operation
- Rotation pointer `rr[1:0]` cycles 0 (lft), 1 (rght), 2 (batt), 0, and so on. It advances only on completion of a conversion. Value 3 is never reached.
- States:
  - IDLE: on `nxt` or `pend`, go to SEND1 and clear `pend`.
  - SEND1: assert `wrt` with `cmd` for the `rr` channel, then go to WAIT1.
  - WAIT1: on `done`, go to GAP.
  - GAP: one dead cycle, then go to SEND2.
  - SEND2: assert `wrt` with the same `cmd`, then go to WAIT2.
  - WAIT2: on `done`, latch `rd_data[11:0]` into the `rr` register, pulse `cnv_cmplt`, advance `rr`, go to IDLE.
- The first transaction selects the channel. The A2D returns data for the channel selected in the previous transaction, so only the second `rd_data` is used and `rd_data[15:12]` is ignored.
- Pending request:
  - `nxt` outside IDLE sets `pend`. Further `nxt` while `pend` is set are dropped; there is no counting.
  - `nxt` in IDLE the same cycle as a WAIT2 completion cannot occur, because the FSM is not in IDLE then. A `nxt` on the WAIT2 completion cycle sets `pend`.
- `all_vld` is a sticky flag set on the first batt update when lft and rght have already updated. Because rotation is fixed, this means the third completion after reset.
- `cmd` holds its value between strobes and changes only when entering SEND1.
- `done` outside WAIT1/WAIT2 is ignored.

## Timing
- Reset values:
  - State IDLE, `rr`=0, `pend`=0, `wrt`=0, `cmd`=16'h0000.
  - `lft_ld`/`rght_ld`/`batt`=12'h000.
  - `cnv_cmplt`=0, `all_vld`=0, `batt_low`=0.
- `wrt` is registered:
  - High exactly the cycle after `nxt` is sampled in IDLE.
  - The second `wrt` is 2 cycles after the first `done`.
- The holding register and `cnv_cmplt` update on the clock edge after the second `done`.
- Back-to-back: with `pend` set, SEND1 is entered the cycle after WAIT2 completes, with no idle cycle lost beyond the IDLE pass.
- A reset mid-conversion returns the block immediately to reset values. The SPI master is reset by the same `rst_n`.

## Configuration
- `A2D_BATT_CHK_EN` defined:
  - `batt_low` is registered and updates with each batt latch: `batt_low = (new batt < BATT_THRESH)`.
  - It holds otherwise and resets to 0.
- `A2D_BATT_CHK_EN` undefined: the `batt_low` port and comparator are absent.

## Test plan
- Reset, ADC model lft=12'h130, rght=12'h190, batt=12'h9A0; pulse `nxt` three times, each after `cnv_cmplt` -> `lft_ld`=12'h130, `rght_ld`=12'h190, `batt`=12'h9A0, and `all_vld` rises with the third `cnv_cmplt`.
- Check `cmd` per conversion -> 16'h0000, 16'h2000, 16'h2800 in order. The fourth conversion uses 16'h0000.
- Three `nxt` pulses during one conversion -> exactly two conversions total, the second starting the cycle after IDLE is re-entered.
- Hold SPI `done` off for 100 cycles in WAIT1 -> no second `wrt` and no register change. After `done`, `wrt` follows 2 cycles later.
- Assert `rst_n` low during WAIT2 -> all outputs at reset values, `rr`=0. The next `nxt` converts the left channel.
- With `A2D_BATT_CHK_EN`, batt=12'h7FF -> `batt_low`=1 after the batt conversion. With batt=12'h800 -> `batt_low`=0.
